config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 181 ++++++++++++++++++
 tb/tb_config_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Serial configuration loader: streams host words bit-serially into a PE config chain.
// Optional readback verification of the chain is enabled by defining LOADER_READBACK_EN.
module config_loader #(
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              chain_data,
    output logic              chain_shift,
    output logic              chain_reset,
    input  logic              chain_tap,
    output logic              busy,
    output logic              done,
    output logic              mismatch
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

`ifdef LOADER_READBACK_EN
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_VERIFY, S_DONE} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_e;
`endif

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  buf_q, buf_d;
    logic               full_q, full_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   req_q, req_d;
    logic [CNT_W-1:0]   req_sat;
`ifdef LOADER_READBACK_EN
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic                 mismatch_q, mismatch_d;
`endif

    logic load_shift, last_bit, word_end, drain, ready, accept;

    // Buffer drains on its last word bit or on the final chain bit, so the next word can land the same cycle
    always_comb begin
        load_shift = (state_q == S_LOAD) && full_q;
        last_bit   = (cnt_q == CNT_W'(CHAIN_LEN - 1));
        word_end   = (idx_q == IDX_W'(WORD_W - 1));
        drain      = load_shift && (word_end || last_bit);
        ready      = (state_q == S_LOAD) && (!full_q || drain) && (32'(req_q) < CHAIN_LEN);
        accept     = ready && word_valid;
        if (32'(req_q) + WORD_W >= CHAIN_LEN) begin
            req_sat = CNT_W'(CHAIN_LEN);
        end else begin
            req_sat = CNT_W'(32'(req_q) + WORD_W);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_LOAD;
`ifdef LOADER_READBACK_EN
            S_LOAD:   if (load_shift && last_bit) state_d = S_VERIFY;
            S_VERIFY: if (last_bit) state_d = S_DONE;
`else
            S_LOAD:   if (load_shift && last_bit) state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        word_ready  = 1'b0;
        chain_data  = 1'b0;
        chain_shift = 1'b0;
        chain_reset = 1'b0;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        mismatch    = 1'b0;
        case (state_q)
            S_CLEAR: chain_reset = 1'b1;
            S_LOAD: begin
                word_ready  = ready;
                chain_shift = full_q;
                chain_data  = full_q & buf_q[0];
            end
`ifdef LOADER_READBACK_EN
            S_VERIFY: begin
                chain_shift = 1'b1;
                chain_data  = chain_tap;
            end
`endif
            default: ;
        endcase
`ifdef LOADER_READBACK_EN
        mismatch = mismatch_q;
`endif
    end

    always_comb begin
        buf_d  = buf_q;
        full_d = full_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        req_d  = req_q;
`ifdef LOADER_READBACK_EN
        shadow_d   = shadow_q;
        mismatch_d = mismatch_q;
`endif
        if ((state_q == S_IDLE) && start) begin
            full_d = 1'b0;
            idx_d  = '0;
            cnt_d  = '0;
            req_d  = '0;
`ifdef LOADER_READBACK_EN
            mismatch_d = 1'b0;
`endif
        end
        if (load_shift) begin
            buf_d = buf_q >> 1;
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (drain) full_d = 1'b0;
`ifdef LOADER_READBACK_EN
            shadow_d = (shadow_q >> 1) | (CHAIN_LEN'(buf_q[0]) << (CHAIN_LEN - 1));
            if (last_bit) cnt_d = '0;
`endif
        end
        if (accept) begin
            buf_d  = word_in;
            full_d = 1'b1;
            idx_d  = '0;
            req_d  = req_sat;
        end
`ifdef LOADER_READBACK_EN
        // Rotate the shadow alongside the recirculating chain; bit 0 always lines up with the tap
        if (state_q == S_VERIFY) begin
            cnt_d    = cnt_q + 1'b1;
            shadow_d = (shadow_q >> 1) | (CHAIN_LEN'(shadow_q[0]) << (CHAIN_LEN - 1));
            if (chain_tap != shadow_q[0]) mismatch_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q  <= '0;
            full_q <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
            req_q  <= '0;
`ifdef LOADER_READBACK_EN
            shadow_q   <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            buf_q  <= buf_d;
            full_q <= full_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
`ifdef LOADER_READBACK_EN
            shadow_q   <= shadow_d;
            mismatch_q <= mismatch_d;
`endif
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: default 16/8 instance plus a 10/8 instance.
// Expectations adapt to LOADER_READBACK_EN when it is defined for the build.
module tb_config_loader;

`ifdef LOADER_READBACK_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] word_in = 8'h00;
    logic       word_valid = 1'b0;
    logic       word_ready, chain_data, chain_shift, chain_reset, busy, done, mismatch;
    logic       chain_tap;

    logic       start10 = 1'b0;
    logic [7:0] word_in10 = 8'h00;
    logic       word_valid10 = 1'b0;
    logic       word_ready10, chain_data10, chain_shift10, chain_reset10, busy10, done10, mismatch10;
    logic       chain_tap10 = 1'b0;

    int nvec = 0;
    int nerr = 0;

    config_loader u_dut (
        .clk(clk), .reset(reset), .start(start), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .chain_data(chain_data), .chain_shift(chain_shift),
        .chain_reset(chain_reset), .chain_tap(chain_tap), .busy(busy), .done(done),
        .mismatch(mismatch)
    );

    config_loader #(.CHAIN_LEN(10), .WORD_W(8)) u_dut10 (
        .clk(clk), .reset(reset), .start(start10), .word_in(word_in10), .word_valid(word_valid10),
        .word_ready(word_ready10), .chain_data(chain_data10), .chain_shift(chain_shift10),
        .chain_reset(chain_reset10), .chain_tap(chain_tap10), .busy(busy10), .done(done10),
        .mismatch(mismatch10)
    );

    always #5 clk = ~clk;

    // 16-bit PE chain model: new bit enters the MSB, tap is bit 0
    logic [15:0] model = 16'h0;
    int          mshift = 0;
    bit          fault_en = 1'b0;
    assign chain_tap = model[0];

    always @(posedge clk) begin
        if (chain_reset) begin
            model  <= 16'h0;
            mshift <= 0;
        end else if (chain_shift) begin
            model  <= {chain_data, model[15:1]} ^ ((fault_en && mshift == 15) ? 16'h0080 : 16'h0000);
            mshift <= mshift + 1;
        end
    end

    logic [7:0]  wds [2];
    logic [15:0] lbits;
    int nbits, nbusy, ndone, nclr, nacc, ngaps, first_sh, last_sh;
    bit clr_first;

    // Run one load on the 16-bit instance; period sets word_valid cadence,
    // rst_at>=0 asserts reset after that many shifts, start_at>=0 re-pulses start mid-load.
    task automatic run_load(input int period, input int rst_at, input int start_at);
        int  widx;
        bit  acc, seen_busy, finished;
        nbits = 0; nbusy = 0; ndone = 0; nclr = 0; nacc = 0; ngaps = 0;
        first_sh = -1; last_sh = -1; lbits = 16'h0; clr_first = 1'b0;
        widx = 0; seen_busy = 1'b0; finished = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            word_valid = ((cyc % period) == 0);
            word_in    = (widx < 2) ? wds[widx] : 8'h00;
            if (cyc == 0) clr_first = chain_reset;
            if (busy) begin
                nbusy++;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                finished = 1'b1;
                break;
            end
            if (done) ndone++;
            if (chain_reset) nclr++;
            if (word_ready && !chain_shift) begin
                ngaps++;
                nvec++;
                if (int'(u_dut.cnt_q) !== nbits) begin
                    nerr++;
                    $display("FAIL stall_count cyc=%0d got=%0d want=%0d", cyc, u_dut.cnt_q, nbits);
                end
            end
            if (chain_shift) begin
                if (nbits < 16) begin
                    lbits[nbits] = chain_data;
                    last_sh = cyc;
                    if (first_sh < 0) first_sh = cyc;
                end
                nbits++;
            end
            start = (start_at >= 0) && chain_shift && (nbits == start_at);
            if (rst_at >= 0 && nbits == rst_at) begin
                #2 reset = 1'b1;
                #1;
                nvec++;
                if ({chain_data, chain_shift, chain_reset, word_ready, busy, done, mismatch} !== 7'b0) begin
                    nerr++;
                    $display("FAIL reset_outputs got=%b want=0000000",
                             {chain_data, chain_shift, chain_reset, word_ready, busy, done, mismatch});
                end
                nvec++;
                if (u_dut.cnt_q !== 5'd0 || u_dut.full_q !== 1'b0) begin
                    nerr++;
                    $display("FAIL reset_counters cnt=%0d full=%b want=0/0", u_dut.cnt_q, u_dut.full_q);
                end
                @(posedge clk); #1;
                reset = 1'b0;
                word_valid = 1'b0;
                return;
            end
            acc = word_ready && word_valid;
            if (acc) nacc++;
            @(posedge clk); #1;
            if (acc) widx++;
        end
        word_valid = 1'b0;
        nvec++;
        if (!finished) begin
            nerr++;
            $display("FAIL load_timeout got=still_busy want=idle");
        end
    endtask

    task automatic check_full_load(input string tag, input int exp_busy, input int exp_gaps);
        nvec++;
        if (clr_first !== 1'b1 || nclr !== 1) begin
            nerr++;
            $display("FAIL %s chain_reset first=%b cycles=%0d want=1/1", tag, clr_first, nclr);
        end
        nvec++;
        if (lbits !== 16'h3CA5) begin
            nerr++;
            $display("FAIL %s bits got=%h want=3ca5", tag, lbits);
        end
        nvec++;
        if (nbits !== 16 * (1 + VER)) begin
            nerr++;
            $display("FAIL %s shifts got=%0d want=%0d", tag, nbits, 16 * (1 + VER));
        end
        nvec++;
        if (ndone !== 1) begin
            nerr++;
            $display("FAIL %s done_pulses got=%0d want=1", tag, ndone);
        end
        nvec++;
        if (nbusy !== exp_busy) begin
            nerr++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", tag, nbusy, exp_busy);
        end
        nvec++;
        if (nacc !== 2 || ngaps !== exp_gaps) begin
            nerr++;
            $display("FAIL %s accepts/gaps got=%0d/%0d want=2/%0d", tag, nacc, ngaps, exp_gaps);
        end
    endtask

    task automatic test_reset();
        nvec++;
        if ({chain_data, chain_shift, chain_reset, word_ready, busy, done, mismatch} !== 7'b0) begin
            nerr++;
            $display("FAIL por_outputs got=%b want=0000000",
                     {chain_data, chain_shift, chain_reset, word_ready, busy, done, mismatch});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_load(1, -1, -1);
        check_full_load("basic", 19 + 16 * VER, 1);
        nvec++;
        if (last_sh - first_sh !== 15) begin
            nerr++;
            $display("FAIL basic contiguous span got=%0d want=15", last_sh - first_sh);
        end
        nvec++;
        if (model !== 16'h3CA5) begin
            nerr++;
            $display("FAIL basic model got=%h want=3ca5", model);
        end
    endtask

    task automatic test_sparse();
        for (int p = 3; p <= 4; p++) begin
            run_load(p, -1, -1);
            check_full_load($sformatf("sparse%0d", p), 22 + 16 * VER, 4);
        end
    endtask

    task automatic test_mid_reset();
        run_load(1, 5, -1);
        nvec++;
        if (nbits !== 5) begin
            nerr++;
            $display("FAIL mid_reset shifts_before got=%0d want=5", nbits);
        end
        run_load(1, -1, -1);
        check_full_load("after_reset", 19 + 16 * VER, 1);
    endtask

    task automatic test_start_busy();
        run_load(1, -1, 4);
        check_full_load("start_busy", 19 + 16 * VER, 1);
    endtask

    task automatic test_len10();
        logic [7:0] w10 [3];
        logic [9:0] b10;
        int w, nb, na, nd;
        bit seen, fin, acc;
        w10[0] = 8'hFF; w10[1] = 8'h02; w10[2] = 8'h55;
        w = 0; nb = 0; na = 0; nd = 0; seen = 1'b0; fin = 1'b0; b10 = 10'h0;
        start10 = 1'b1;
        @(posedge clk); #1;
        start10 = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            word_valid10 = 1'b1;
            word_in10    = w10[w];
            if (busy10) seen = 1'b1;
            else if (seen) begin
                fin = 1'b1;
                break;
            end
            if (done10) nd++;
            if (chain_shift10) begin
                if (nb < 10) b10[nb] = chain_data10;
                nb++;
            end
            acc = word_ready10 && word_valid10;
            if (acc) na++;
            @(posedge clk); #1;
            if (acc && w < 2) w++;
        end
        word_valid10 = 1'b0;
        nvec++;
        if (!fin) begin
            nerr++;
            $display("FAIL len10_timeout got=still_busy want=idle");
        end
        nvec++;
        if (b10 !== 10'h2FF) begin
            nerr++;
            $display("FAIL len10 bits got=%h want=2ff", b10);
        end
        nvec++;
        if (nb !== 10 * (1 + VER)) begin
            nerr++;
            $display("FAIL len10 shifts got=%0d want=%0d", nb, 10 * (1 + VER));
        end
        nvec++;
        if (na !== 2 || nd !== 1) begin
            nerr++;
            $display("FAIL len10 accepts/done got=%0d/%0d want=2/1", na, nd);
        end
    endtask

    task automatic test_readback();
        fault_en = 1'b1;
        run_load(1, -1, -1);
        fault_en = 1'b0;
        nvec++;
        if (mismatch !== 1'(VER)) begin
            nerr++;
            $display("FAIL readback_fault mismatch got=%b want=%0d", mismatch, VER);
        end
        nvec++;
        if (model !== 16'h3C25) begin
            nerr++;
            $display("FAIL readback_fault model got=%h want=3c25", model);
        end
        run_load(1, -1, -1);
        nvec++;
        if (mismatch !== 1'b0) begin
            nerr++;
            $display("FAIL readback_clean mismatch got=%b want=0", mismatch);
        end
        nvec++;
        if (model !== 16'h3CA5) begin
            nerr++;
            $display("FAIL readback_clean model got=%h want=3ca5", model);
        end
    endtask

    initial begin
        wds[0] = 8'hA5;
        wds[1] = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_sparse();
        test_mid_reset();
        test_start_busy();
        test_len10();
        test_readback();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
